sos_detector: RTL and testbench
===============================

// Module: sos_detector
// PURPOSE
//  Downstream consumer of sos_driver's serial Morse stream (one sample per clk).
//  - Measures high/low run lengths and classifies high runs as dot or dash.
//  - Assembles the elements into letters S (...) / O (---) / OTHER.
//  - Pulses detected when the letter sequence S,O,S completes.
// PARAMETERS
//  DOT_MAX   1  high run of 1..DOT_MAX cycles = dot
//  DASH_MAX  3  high run of DOT_MAX+1..DASH_MAX = dash; longer = bad element
//  LGAP      3  consecutive low samples that close a letter
//  WGAP      7  consecutive low samples that reset the sequence FSM (WGAP > LGAP)
//  CNT_W     4  run counter width; saturates at 2**CNT_W-1 (must exceed WGAP)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  data_in      in   1  serial Morse line (sos_driver dataOut)
//  letter_valid out  1  1-cycle pulse: a letter completed
//  letter_code  out  2  00 OTHER, 01 S, 10 O; valid only with letter_valid
//  detected     out  1  1-cycle pulse: S,O,S completed
//  seq_state    out  2  debug: current sequence FSM state
// BEHAVIOUR
//  Reset: all outputs 0. prev sample = 0. Low counter preset saturated, so no
//   spurious letter or word gap follows reset. Reset mid-letter discards the letter.
//  Run counting (per edge): same value as prev -> counter+1 (saturating);
//   value change -> counter = 1.
//  Falling edge (prev=1, data_in=0): classify the finished high run.
//   - Dot or dash: element count +1; dots/dashes tallied.
//   - Longer than DASH_MAX: letter bad flag set.
//   - A 4th element also sets the bad flag; element count saturates at 4.
//  Letter close: on the edge where the low count becomes exactly LGAP, if element
//   count > 0: letter_valid=1 for one cycle.
//   - letter_code = S if exactly 3 dots, 0 dashes, not bad.
//   - letter_code = O if exactly 3 dashes, 0 dots, not bad.
//   - Otherwise OTHER.
//   - Element count, tallies and bad flag clear on the same edge.
//  Latency: outputs are registered. letter_valid is high during the cycle following
//   the edge that samples the LGAP-th consecutive 0.
//  Sequence FSM (advances only on letter_valid):
//   - SEQ_IDLE: S->SEQ_S; else stay.
//   - SEQ_S:    O->SEQ_SO; S->SEQ_S; OTHER->SEQ_IDLE.
//   - SEQ_SO:   S->SEQ_S and detected=1 (the trailing S may start the next SOS);
//               O/OTHER->SEQ_IDLE.
//   - detected is asserted in the same cycle as the letter_valid of the final S.
//  Word gap: on the edge where the low count becomes exactly WGAP, the FSM goes to
//   SEQ_IDLE. This has no effect on letter_valid, which already fired at LGAP.
//  Long high (never falls): no letter event. Classification happens only on the
//   falling edge, and the saturated run counts as bad.
//  seq_state encoding: 00 IDLE, 01 S, 10 SO.
// STRUCTURE
//  sos_defs.vh (`include, shared with sos_driver and the benches):
//   - letter codes L_OTHER/L_S/L_O.
//   - FSM state codes SEQ_IDLE/SEQ_S/SEQ_SO.
//   - default timing constants.
//  Sub-module sos_symbol_classifier: run counters plus dot/dash/bad classification.
//   - Outputs elem_valid, elem_is_dash, elem_bad.
//   - Outputs letter_gap and word_gap strobes.
//  Top level: letter assembly plus the sequence FSM.
// TESTING (defaults; S=10101000, O=11101110111000)
//  1. rst 2 cycles, then data_in=0 for 20 cycles.
//     -> no letter_valid, no detected, seq_state=00.
//  2. Stream S,O,S back-to-back.
//     -> letter_valid x3 with codes 01,10,01.
//     -> detected one cycle, coincident with the 3rd letter_valid.
//     -> seq_state ends at 01.
//  3. Stream S,O,S,O,S.
//     -> detected pulses twice (overlap on the middle S).
//  4. Stream S, then 7 zeros, then O,S.
//     -> word gap resets the FSM after the first S; detected never asserts.
//  5. Stream 11110 then 000 (over-long dash), and 1010101000 (4 dots).
//     -> letter_code=00 for both.
//  6. Assert rst in the middle of the second dash of O, then stream S,O,S.
//     -> partial letter discarded, no letter_valid for it.
//     -> the following S,O,S detects once.

Source files
------------

// File: rtl/sos_detector_pkg.sv
// Shared constants, letter accumulator type and letter decode for the SOS detector.
package sos_detector_pkg;

   localparam int unsigned DOT_MAX_DEF  = 1;
   localparam int unsigned DASH_MAX_DEF = 3;
   localparam int unsigned LGAP_DEF     = 3;
   localparam int unsigned WGAP_DEF     = 7;
   localparam int unsigned CNT_W_DEF    = 4;
   localparam int unsigned ELEM_W       = 3;

   localparam logic [1:0] L_OTHER = 2'b00;
   localparam logic [1:0] L_S     = 2'b01;
   localparam logic [1:0] L_O     = 2'b10;

   localparam logic [1:0] SEQ_IDLE = 2'b00;
   localparam logic [1:0] SEQ_S    = 2'b01;
   localparam logic [1:0] SEQ_SO   = 2'b10;

   typedef struct packed {
      logic [ELEM_W-1:0] elems;
      logic [ELEM_W-1:0] dots;
      logic [ELEM_W-1:0] dashes;
      logic              bad;
   } letter_acc_t;

   // Three clean dots make S, three clean dashes make O, anything else is OTHER.
   function automatic logic [1:0] classify_letter(input letter_acc_t acc);
      if (!acc.bad && acc.dots == ELEM_W'(3) && acc.dashes == ELEM_W'(0))
         return L_S;
      if (!acc.bad && acc.dashes == ELEM_W'(3) && acc.dots == ELEM_W'(0))
         return L_O;
      return L_OTHER;
   endfunction

endpackage

// File: rtl/sos_detector_if.sv
// Serial Morse input and letter/detection outputs of the SOS detector.
interface sos_detector_if;
   logic       data_in;
   logic       letter_valid;
   logic [1:0] letter_code;
   logic       detected;
   logic [1:0] seq_state;

   modport master (output data_in, input letter_valid, input letter_code,
                   input detected, input seq_state);
   modport slave  (input data_in, output letter_valid, output letter_code,
                   output detected, output seq_state);
endinterface

// File: rtl/sos_detector_classifier.sv
// Run-length counter on the serial line; strobes dot/dash/bad elements and gaps.
module sos_detector_classifier
   import sos_detector_pkg::*;
#(
   parameter int unsigned DOT_MAX  = DOT_MAX_DEF,
   parameter int unsigned DASH_MAX = DASH_MAX_DEF,
   parameter int unsigned LGAP     = LGAP_DEF,
   parameter int unsigned WGAP     = WGAP_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic data,
   output logic elem_valid_c,
   output logic elem_is_dash_c,
   output logic elem_bad_c,
   output logic letter_gap_c,
   output logic word_gap_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             prev;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             fall;

   // cnt is the length of the run of 'prev' values seen so far
   always_comb begin
      cnt_next = CNT_W'(1);
      if (data == prev)
         cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   end

   assign fall           = prev & ~data;
   assign elem_valid_c   = fall;
   assign elem_bad_c     = fall && (cnt > CNT_W'(DASH_MAX));
   assign elem_is_dash_c = fall && (cnt > CNT_W'(DOT_MAX)) && !(cnt > CNT_W'(DASH_MAX));
   assign letter_gap_c   = !data && (cnt_next == CNT_W'(LGAP));
   assign word_gap_c     = !data && (cnt_next == CNT_W'(WGAP));

   // Low count preset saturated so no gap strobe follows reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b0;
         cnt  <= CNT_MAX;
      end else begin
         prev <= data;
         cnt  <= cnt_next;
      end
   end

endmodule

// File: rtl/sos_detector.sv
// Assembles Morse elements into letters and pulses detected on S,O,S.
module sos_detector
   import sos_detector_pkg::*;
#(
   parameter int unsigned DOT_MAX  = DOT_MAX_DEF,
   parameter int unsigned DASH_MAX = DASH_MAX_DEF,
   parameter int unsigned LGAP     = LGAP_DEF,
   parameter int unsigned WGAP     = WGAP_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   sos_detector_if.slave bus
);

   logic        elem_valid_c;
   logic        elem_is_dash_c;
   logic        elem_bad_c;
   logic        letter_gap_c;
   logic        word_gap_c;

   letter_acc_t acc_q, acc_d;
   logic [1:0]  seq_q, seq_d;
   logic        close_c;
   logic [1:0]  code_c;
   logic        det_c;
   logic        letter_valid_q;
   logic [1:0]  letter_code_q;
   logic        detected_q;

   sos_detector_classifier #(
      .DOT_MAX  (DOT_MAX),
      .DASH_MAX (DASH_MAX),
      .LGAP     (LGAP),
      .WGAP     (WGAP),
      .CNT_W    (CNT_W)
   ) u_classifier (
      .clk            (clk),
      .rst            (rst),
      .data           (bus.data_in),
      .elem_valid_c   (elem_valid_c),
      .elem_is_dash_c (elem_is_dash_c),
      .elem_bad_c     (elem_bad_c),
      .letter_gap_c   (letter_gap_c),
      .word_gap_c     (word_gap_c)
   );

   // Letter accumulation; element count saturates at 4 and the 4th marks it bad
   always_comb begin
      acc_d   = acc_q;
      close_c = letter_gap_c && (acc_q.elems != ELEM_W'(0));
      code_c  = classify_letter(acc_q);
      if (letter_gap_c) begin
         acc_d = '0;
      end else if (elem_valid_c) begin
         if (acc_q.elems >= ELEM_W'(3) || elem_bad_c)
            acc_d.bad = 1'b1;
         if (acc_q.elems != ELEM_W'(4)) begin
            acc_d.elems = acc_q.elems + ELEM_W'(1);
            if (!elem_bad_c && elem_is_dash_c)
               acc_d.dashes = acc_q.dashes + ELEM_W'(1);
            else if (!elem_bad_c)
               acc_d.dots = acc_q.dots + ELEM_W'(1);
         end
      end
   end

   // Sequence FSM next state; a word gap always returns to idle
   always_comb begin
      seq_d = seq_q;
      det_c = 1'b0;
      if (word_gap_c) begin
         seq_d = SEQ_IDLE;
      end else if (close_c) begin
         case (seq_q)
            SEQ_IDLE: seq_d = (code_c == L_S) ? SEQ_S : SEQ_IDLE;
            SEQ_S: begin
               if (code_c == L_O)      seq_d = SEQ_SO;
               else if (code_c == L_S) seq_d = SEQ_S;
               else                    seq_d = SEQ_IDLE;
            end
            SEQ_SO: begin
               if (code_c == L_S) begin
                  seq_d = SEQ_S;
                  det_c = 1'b1;
               end else begin
                  seq_d = SEQ_IDLE;
               end
            end
            default: seq_d = SEQ_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q          <= '0;
         seq_q          <= SEQ_IDLE;
         letter_valid_q <= 1'b0;
         letter_code_q  <= L_OTHER;
         detected_q     <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         seq_q          <= seq_d;
         letter_valid_q <= close_c;
         letter_code_q  <= close_c ? code_c : L_OTHER;
         detected_q     <= det_c;
      end
   end

   assign bus.letter_valid = letter_valid_q;
   assign bus.letter_code  = letter_code_q;
   assign bus.detected     = detected_q;
   assign bus.seq_state    = seq_q;

endmodule

// File: tb/tb_sos_detector.sv
// Directed and randomized Morse streams checked cycle by cycle against a letter-level model.
module tb_sos_detector;
   import sos_detector_pkg::*;

   localparam int unsigned DOT_MAX  = 1;
   localparam int unsigned DASH_MAX = 3;
   localparam int unsigned LGAP     = 3;
   localparam int unsigned WGAP     = 7;

   localparam string S_STR = "10101000";
   localparam string O_STR = "11101110111000";

   logic clk = 1'b0;
   logic rst;
   sos_detector_if bus ();

   sos_detector dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_lv     = 0;
   int n_det    = 0;

   // Reference model state: high run lengths of the open letter, letters since the last word gap
   int         hi_run;
   int         low_run;
   int         runs[$];
   logic [1:0] letters[$];
   logic       exp_lv;
   logic [1:0] exp_code;
   logic       exp_det;
   logic [1:0] exp_seq;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] decode_runs();
      int n_dot  = 0;
      int n_dash = 0;
      foreach (runs[i]) begin
         if (runs[i] >= 1 && runs[i] <= int'(DOT_MAX))      n_dot++;
         else if (runs[i] <= int'(DASH_MAX))               n_dash++;
      end
      if (runs.size() == 3 && n_dot == 3)  return L_S;
      if (runs.size() == 3 && n_dash == 3) return L_O;
      return L_OTHER;
   endfunction

   task automatic model_step(input logic d, input logic r);
      int n;
      exp_lv   = 1'b0;
      exp_code = L_OTHER;
      exp_det  = 1'b0;
      if (r) begin
         hi_run  = 0;
         low_run = 1000;
         runs.delete();
         letters.delete();
         exp_seq = SEQ_IDLE;
         return;
      end
      if (d) begin
         hi_run++;
         low_run = 0;
      end else begin
         if (hi_run > 0) runs.push_back(hi_run);
         hi_run = 0;
         low_run++;
         if (low_run == int'(LGAP) && runs.size() > 0) begin
            exp_lv   = 1'b1;
            exp_code = decode_runs();
            runs.delete();
            letters.push_back(exp_code);
            n = letters.size();
            if (n >= 3 && letters[n-3] == L_S && letters[n-2] == L_O && letters[n-1] == L_S)
               exp_det = 1'b1;
         end
         if (low_run == int'(WGAP)) letters.delete();
      end
      n = letters.size();
      if (n >= 1 && letters[n-1] == L_S)                            exp_seq = SEQ_S;
      else if (n >= 2 && letters[n-2] == L_S && letters[n-1] == L_O) exp_seq = SEQ_SO;
      else                                                          exp_seq = SEQ_IDLE;
   endtask

   // One clock: drive, advance the model, then compare away from the edge
   task automatic send(input logic d, input logic r);
      bus.data_in = d;
      rst         = r;
      @(posedge clk);
      model_step(d, r);
      #1;
      check("letter_valid", 32'(bus.letter_valid), 32'(exp_lv));
      check("detected", 32'(bus.detected), 32'(exp_det));
      check("seq_state", 32'(bus.seq_state), 32'(exp_seq));
      if (exp_lv) check("letter_code", 32'(bus.letter_code), 32'(exp_code));
      if (bus.letter_valid) n_lv++;
      if (bus.detected)     n_det++;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i] == "1", 1'b0);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b1);
      n_lv  = 0;
      n_det = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.data_in = 1'b0;
      rst         = 1'b1;

      // Reset then idle line
      do_reset(2);
      check("reset_lv", 32'(bus.letter_valid), 0);
      check("reset_code", 32'(bus.letter_code), 0);
      send_zeros(20);
      check("idle_lv_count", 32'(n_lv), 0);
      check("idle_det_count", 32'(n_det), 0);

      // S,O,S back to back
      do_reset(2);
      send_str(S_STR); send_str(O_STR); send_str(S_STR);
      check("sos_lv_count", 32'(n_lv), 3);
      check("sos_det_count", 32'(n_det), 1);
      check("sos_final_seq", 32'(bus.seq_state), 32'(SEQ_S));

      // Overlapping S,O,S,O,S
      do_reset(2);
      send_str(S_STR); send_str(O_STR); send_str(S_STR); send_str(O_STR); send_str(S_STR);
      check("overlap_det_count", 32'(n_det), 2);

      // Word gap after the first S
      do_reset(2);
      send_str(S_STR); send_zeros(7); send_str(O_STR); send_str(S_STR);
      check("wgap_det_count", 32'(n_det), 0);
      check("wgap_lv_count", 32'(n_lv), 3);

      // Over-long dash and four dots both decode as OTHER
      do_reset(2);
      send_str("11110"); send_zeros(3);
      send_str("1010101000");
      check("bad_lv_count", 32'(n_lv), 2);

      // Reset in the middle of the second dash of O
      do_reset(2);
      send_str("111011");
      do_reset(2);
      send_str(S_STR); send_str(O_STR); send_str(S_STR);
      check("midrst_lv_count", 32'(n_lv), 3);
      check("midrst_det_count", 32'(n_det), 1);

      // Randomized mixture of letters, noise, gaps and occasional resets
      do_reset(2);
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 6))
            0, 1: send_str(S_STR);
            2, 3: send_str(O_STR);
            4: begin
               int len = $urandom_range(1, 8);
               for (int b = 0; b < len; b++) send(1'($urandom_range(0, 1)), 1'b0);
            end
            5: send_zeros($urandom_range(1, 9));
            default: begin
               if ($urandom_range(0, 9) == 0) send(1'b0, 1'b1);
               else send_str("1110111000");
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
